// File: rtl/dmem_ctrl_pkg.sv
// Shared constants for the data-memory access controller: state encoding
// and the default request timeout.
package dmem_ctrl_pkg;

    // Width of the REQ/WAIT watchdog counter.
    localparam int unsigned TIMER_W         = 8;
    // Last timer value at which a pending request may still complete.
    localparam int unsigned TIMEOUT_DEFAULT = 255;

    // Controller states, 3-bit encoding.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd3;
    localparam logic [2:0] ST_DUMP = 3'd4;
    localparam logic [2:0] ST_HALT = 3'd5;
    localparam logic [2:0] ST_ERR  = 3'd6;

endpackage

// File: rtl/wait_timer.sv
// Clear/enable up-counter with a terminal-count compare. Used to bound how
// long the controller may sit in REQ/WAIT waiting for the memory.
module wait_timer
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned     W  = TIMER_W,
    parameter logic [W-1:0]    TC = W'(TIMEOUT_DEFAULT)
)(
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear wins over enable so a fresh request always starts counting at 0.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC);

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: turns the memory-stage decode controls into
// a single request to a variable-latency memory, stalls the pipeline until it
// completes, returns load data, runs the halt/dump sequence and traps on
// unaligned accesses or memory timeouts.
//
// Memory handshake: the controller holds mem_en (with mem_addr/mem_wr/
// mem_wdata stable) while in REQ; the memory takes the request on a cycle
// where mem_en=1 and mem_stall=0. It then signals completion with a single
// mem_done pulse, either in that same accept cycle or any later cycle, with
// mem_rdata valid alongside mem_done for loads. mem_done is only observed
// while a request is outstanding (REQ/WAIT).
module dmem_access_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dmem_en,
    input  logic              dmem_write,
    input  logic              dmem_dump,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              mem_stall,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_dump,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              halted,
    output logic              err,
    output logic [2:0]        dbg_state
);

    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_wr_q;
    logic [DATA_W-1:0] rdata_q;
    logic              capture;
    logic              pending;
    logic              complete;
    logic              timer_clr;
    logic              timer_tc;

    // Next-state logic; new requests are sampled only in IDLE and DONE.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (dmem_dump) begin
                    state_d = ST_DUMP;
                end else if (dmem_en && addr[0]) begin
                    state_d = ST_ERR;
                end else if (dmem_en) begin
                    state_d = ST_REQ;
                    capture = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (!mem_stall && mem_done) begin
                    state_d = ST_DONE;
                end else if (timer_tc) begin
                    state_d = ST_ERR;
                end else if (!mem_stall) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_done) begin
                    state_d = ST_DONE;
                end else if (timer_tc) begin
                    state_d = ST_ERR;
                end
            end
            ST_DUMP: state_d = ST_HALT;
            ST_HALT: state_d = ST_HALT;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase
    end

    assign pending   = (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign complete  = pending && (state_d == ST_DONE);
    assign timer_clr = (state_d == ST_REQ) && (state_q != ST_REQ);

    wait_timer #(
        .W  (TIMER_W),
        .TC (TIMER_W'(TIMEOUT))
    ) u_wait_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (timer_clr),
        .en_i  (pending),
        .tc_o  (timer_tc)
    );

    // State register plus request capture and load-data latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wr_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                mem_addr_q  <= addr;
                mem_wdata_q <= wdata;
                mem_wr_q    <= dmem_write;
            end
            if (complete && !mem_wr_q) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    // Stall is combinational so the requesting instruction freezes in the
    // same cycle it is decoded.
    always_comb begin
        case (state_q)
            ST_IDLE, ST_DONE: stall = dmem_en | dmem_dump;
            default:          stall = 1'b1;
        endcase
    end

    assign mem_en      = (state_q == ST_REQ);
    assign mem_wr      = mem_wr_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_dump    = (state_q == ST_DUMP);
    assign rdata       = rdata_q;
    assign rdata_valid = (state_q == ST_DONE) && !mem_wr_q;
    assign halted      = (state_q == ST_HALT);
    assign err         = (state_q == ST_ERR);
    assign dbg_state   = state_q;

endmodule
